// File: rtl/argmax_row_scheduler.sv
// Argmax row scheduler: walks every node row of the result memory, scans
// each row element by element and records the winning class index per node.
module argmax_row_scheduler #(
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int READ_LATENCY      = 1,
  parameter int COO_BW            = $clog2(FEATURE_ROWS),
  parameter int MAX_ADDRESS_WIDTH = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]     adj_fm_wm_row,
  output logic [COO_BW-1:0]                              read_row_arg,
  output logic                                           busy,
  output logic                                           done,
  output logic [FEATURE_ROWS-1:0][MAX_ADDRESS_WIDTH-1:0] max_addi_answer
);

  localparam int COL_W  = $clog2(WEIGHT_COLS) + 1;
  localparam int WAIT_W = $clog2(READ_LATENCY + 1) + 1;

  typedef enum logic [2:0] {IDLE, RD, SCAN, WRITE, DONE} state_t;

  state_t                                       state;
  state_t                                       state_next;
  logic [COL_W-1:0]                             col;
  logic [WAIT_W-1:0]                            wait_cnt;
  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]   row_buf;
  logic [DOT_PROD_WIDTH-1:0]                    best_val;
  logic [DOT_PROD_WIDTH-1:0]                    cur_val;
  logic [MAX_ADDRESS_WIDTH-1:0]                 best_idx;
  logic                                         rd_last;
  logic                                         scan_last;
  logic                                         row_last;

  // Terminal-count flags and the element currently under the scan pointer
  always_comb begin
    rd_last   = (wait_cnt == WAIT_W'(READ_LATENCY));
    scan_last = (col == COL_W'(WEIGHT_COLS - 1));
    row_last  = (read_row_arg == COO_BW'(FEATURE_ROWS - 1));
    cur_val   = '0;
    for (int unsigned i = 0; i < WEIGHT_COLS; i++) begin
      if (col == COL_W'(i)) cur_val = row_buf[i];
    end
  end

  // Next-state logic; start only matters in IDLE and DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RD;
      RD:      if (rd_last) state_next = SCAN;
      SCAN:    if (scan_last) state_next = WRITE;
      WRITE:   state_next = row_last ? DONE : RD;
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RD) || (state_next == SCAN) || (state_next == WRITE);
      done  <= (state_next == DONE);
    end
  end

  // Datapath: row address, read wait counter, row capture, scan and result file
  always_ff @(posedge clk) begin
    if (reset) begin
      read_row_arg    <= '0;
      wait_cnt        <= '0;
      col             <= '0;
      row_buf         <= '0;
      best_val        <= '0;
      best_idx        <= '0;
      max_addi_answer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            read_row_arg    <= '0;
            wait_cnt        <= '0;
            max_addi_answer <= '0;
          end
        end
        RD: begin
          if (rd_last) begin
            row_buf  <= adj_fm_wm_row;
            col      <= '0;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        SCAN: begin
          // strict compare keeps the lowest index on ties
          if ((col == '0) || (cur_val > best_val)) begin
            best_val <= cur_val;
            best_idx <= MAX_ADDRESS_WIDTH'(col);
          end
          col <= col + COL_W'(1);
        end
        WRITE: begin
          for (int unsigned i = 0; i < FEATURE_ROWS; i++) begin
            if (read_row_arg == COO_BW'(i)) max_addi_answer[i] <= best_idx;
          end
          if (!row_last) read_row_arg <= read_row_arg + COO_BW'(1);
          wait_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_row_scheduler.sv
// Bench for argmax_row_scheduler: three instances with read latency 0, 1, 2
// share stimulus; expected answers are queued at start and checked at done.
module tb_argmax_row_scheduler;

  localparam int ROWS = 6;
  localparam int COLS = 3;
  localparam int W    = 16;
  localparam int AW   = 2;
  localparam int CB   = 3;

  typedef logic [COLS-1:0][W-1:0] row_t;
  typedef logic [ROWS-1:0][AW-1:0] ans_t;
  typedef struct {
    row_t rows [ROWS];
    ans_t expv;
    bit   hold;
    bit   toggle;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  row_t           mem   [ROWS];
  logic [CB-1:0]  addr  [3];
  row_t           rdata [3];
  logic           busy  [3];
  logic           done  [3];
  ans_t           ans   [3];
  row_t           d1, d2a, d2b;

  int   checks   = 0;
  int   failures = 0;
  ans_t sb [$];
  vec_t tbl [6];

  always #5 clk = ~clk;

  // Memory models: combinational, one-register and two-register read paths
  always @(posedge clk) begin
    d1  <= mem[addr[1]];
    d2a <= mem[addr[2]];
    d2b <= d2a;
  end

  always_comb begin
    rdata[0] = mem[addr[0]];
    rdata[1] = d1;
    rdata[2] = d2b;
  end

  argmax_row_scheduler #(.READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .adj_fm_wm_row(rdata[0]),
    .read_row_arg(addr[0]), .busy(busy[0]), .done(done[0]), .max_addi_answer(ans[0]));
  argmax_row_scheduler #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .adj_fm_wm_row(rdata[1]),
    .read_row_arg(addr[1]), .busy(busy[1]), .done(done[1]), .max_addi_answer(ans[1]));
  argmax_row_scheduler #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .adj_fm_wm_row(rdata[2]),
    .read_row_arg(addr[2]), .busy(busy[2]), .done(done[2]), .max_addi_answer(ans[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic row_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    row_t r;
    r[0] = a;
    r[1] = b;
    r[2] = c;
    return r;
  endfunction

  function automatic ans_t mk_ans(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                  input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                                  input logic [AW-1:0] a4, input logic [AW-1:0] a5);
    ans_t a;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3; a[4] = a4; a[5] = a5;
    return a;
  endfunction

  task automatic check_idle_outputs(input string tag, input ans_t expv);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_busy"}, busy[d], 0);
      chk({tag, "_done"}, done[d], 0);
      chk({tag, "_ans"}, ans[d], expv);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int            cyc  [3];
    bit            seen [3];
    logic [CB-1:0] prev;
    int            n;
    ans_t          e;
    for (int r = 0; r < ROWS; r++) mem[r] = v.rows[r];
    sb.push_back(v.expv);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("start_ans_cleared", ans[d], 0);
      chk("start_busy", busy[d], 1);
      chk("start_addr", addr[d], 0);
      seen[d] = 1'b0;
      cyc[d]  = 0;
    end
    prev = '0;
    n    = 0;
    while (!(seen[0] && seen[1] && seen[2]) && n < 200) begin
      if (!v.hold) start = (v.toggle && n < 27) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      #1;
      n++;
      for (int d = 0; d < 3; d++) begin
        if (!seen[d] && done[d]) begin
          seen[d] = 1'b1;
          cyc[d]  = n;
        end
      end
      if (addr[1] != prev) begin
        chk("addr_step", 32'(addr[1]), 32'(int'(prev) + 1));
        prev = addr[1];
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (!seen[d]) chk("done_timeout", 0, 1);
      else chk("pass_cycles", cyc[d], ROWS * (d + COLS + 2));
    end
    chk("last_addr", addr[1], ROWS - 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      e = '0;
    end else begin
      e = sb.pop_front();
      for (int d = 0; d < 3; d++) chk("answers", ans[d], e);
    end
    if (v.hold) begin
      repeat (4) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        chk("hold_done", done[d], 1);
        chk("hold_busy", busy[d], 0);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("drop_start", e);
    end else begin
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("after_pass", e);
    end
  endtask

  task automatic reset_mid_scan();
    int n;
    for (int r = 0; r < ROWS; r++) mem[r] = tbl[0].rows[r];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (addr[1] != 3'd3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_row3", addr[1], 3);
    // two RD edges, then one SCAN edge: still scanning row 3
    repeat (3) @(posedge clk);
    #1;
    chk("scan_busy", busy[1], 1);
    chk("scan_addr", addr[1], 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("midreset_addr", addr[d], 0);
    check_idle_outputs("midreset", '0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tbl[0].rows = '{mk(1, 5, 2), mk(9, 0, 3), mk(0, 0, 7), mk(4, 4, 1), mk(2, 8, 8), mk(0, 1, 0)};
    tbl[0].expv = mk_ans(1, 0, 2, 0, 1, 1);
    tbl[0].hold = 0; tbl[0].toggle = 0;
    tbl[1].rows = '{mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0), mk(0, 0, 0)};
    tbl[1].expv = mk_ans(0, 0, 0, 0, 0, 0);
    tbl[1].hold = 0; tbl[1].toggle = 0;
    tbl[2].rows = '{mk(0, 16'hFFFF, 16'hFFFF), mk(16'hFFFF, 16'hFFFF, 16'hFFFF), mk(5, 16'hFFFF, 16'hFFFF),
                    mk(1, 2, 16'hFFFF), mk(16'hFFFF, 0, 16'hFFFF), mk(3, 3, 4)};
    tbl[2].expv = mk_ans(1, 0, 1, 2, 0, 2);
    tbl[2].hold = 0; tbl[2].toggle = 0;
    tbl[3].rows = '{mk(16'hFFFF, 16'h7FFF, 16'h8000), mk(16'h7FFF, 16'h8000, 0), mk(0, 16'h7FFF, 16'h8000),
                    mk(16'h8000, 16'h7FFF, 16'hFFFF), mk(1, 0, 0), mk(0, 0, 1)};
    tbl[3].expv = mk_ans(0, 1, 2, 2, 0, 2);
    tbl[3].hold = 0; tbl[3].toggle = 0;
    tbl[4] = tbl[0];
    tbl[4].hold = 1;
    tbl[5] = tbl[3];
    tbl[5].toggle = 1;

    reset = 1'b1;
    start = 1'b0;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("reset_addr", addr[d], 0);
    check_idle_outputs("reset", '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    reset_mid_scan();
    run_vec(tbl[0]);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
